// File: rtl/id_register_file_dbg.sv
// ID-stage register file with N combinational read ports, one synchronous
// write port, asynchronous clear, hardwired-zero r0 and a debug dump engine
// that streams every register over a valid/ready handshake.
// Optional feature macro: REGFILE_WRITE_BYPASS_EN (write-first read bypass).
module id_register_file_dbg #(
    parameter int NB_DATA  = 32,
    parameter int NB_REG   = 5,
    parameter int SIZE_REG = 32,
    parameter int N_READ   = 2
) (
    input  logic                       i_clk,
    input  logic                       i_rst_n,
    input  logic [N_READ*NB_REG-1:0]   i_rd_addr,
    output logic [N_READ*NB_DATA-1:0]  o_rd_data,
    input  logic                       i_write,
    input  logic [NB_REG-1:0]          i_address_data,
    input  logic [NB_DATA-1:0]         i_data_input,
    input  logic                       i_dump_start,
    input  logic                       i_dump_ready,
    output logic                       o_dump_valid,
    output logic [NB_REG-1:0]          o_dump_addr,
    output logic [NB_DATA-1:0]         o_dump_data,
    output logic                       o_dump_busy,
    output logic                       o_dump_done
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DUMP,
        ST_DONE
    } dump_state_t;

    localparam int                LAST_INT = SIZE_REG - 1;
    localparam logic [NB_REG:0]   SIZE_W   = SIZE_REG[NB_REG:0];
    localparam logic [NB_REG-1:0] LAST_IDX = LAST_INT[NB_REG-1:0];

    logic [NB_DATA-1:0] regs [SIZE_REG];
    logic               wr_ok;
    logic [NB_REG-1:0]  next_idx;
    logic [NB_DATA-1:0] next_data;
    logic               accept;
    dump_state_t        state;

    function automatic logic in_range(input logic [NB_REG-1:0] a);
        return ({1'b0, a} < SIZE_W);
    endfunction

    // Writes to r0 or beyond the last register are dropped.
    assign wr_ok = i_write && (i_address_data != '0) && in_range(i_address_data);

    // Storage: asynchronous clear of every entry, synchronous write.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            regs <= '{default: '0};
        end else if (wr_ok) begin
            regs[i_address_data] <= i_data_input;
        end
    end

    // Combinational read ports.
    for (genvar k = 0; k < N_READ; k++) begin : g_rd
        logic [NB_REG-1:0]  ra;
        logic [NB_DATA-1:0] stored;

        assign ra     = i_rd_addr[k*NB_REG +: NB_REG];
        assign stored = ((ra != '0) && in_range(ra)) ? regs[ra] : '0;
`ifdef REGFILE_WRITE_BYPASS_EN
        // wr_ok already excludes r0 and out-of-range addresses.
        assign o_rd_data[k*NB_DATA +: NB_DATA] =
            (wr_ok && (ra == i_address_data)) ? i_data_input : stored;
`else
        assign o_rd_data[k*NB_DATA +: NB_DATA] = stored;
`endif
    end

    // Next dump beat: forward a same-edge write so the beat reflects the
    // register contents at the moment it is loaded.
    assign next_idx  = o_dump_addr + 1'b1;
    assign next_data = (wr_ok && (i_address_data == next_idx)) ? i_data_input :
                       in_range(next_idx) ? regs[next_idx] : '0;
    assign accept    = o_dump_valid && i_dump_ready;

    // Dump FSM; o_dump_addr doubles as the beat pointer.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= ST_IDLE;
            o_dump_valid <= 1'b0;
            o_dump_busy  <= 1'b0;
            o_dump_done  <= 1'b0;
            o_dump_addr  <= '0;
            o_dump_data  <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    o_dump_done <= 1'b0;
                    if (i_dump_start) begin
                        state        <= ST_DUMP;
                        o_dump_valid <= 1'b1;
                        o_dump_busy  <= 1'b1;
                        o_dump_addr  <= '0;
                        o_dump_data  <= '0;
                    end
                end
                ST_DUMP: begin
                    if (accept) begin
                        if (o_dump_addr == LAST_IDX) begin
                            state        <= ST_DONE;
                            o_dump_valid <= 1'b0;
                            o_dump_done  <= 1'b1;
                        end else begin
                            o_dump_addr <= next_idx;
                            o_dump_data <= next_data;
                        end
                    end else if (wr_ok && (i_address_data == o_dump_addr)) begin
                        // Stalled beat snoops a write to its own register.
                        o_dump_data <= i_data_input;
                    end
                end
                ST_DONE: begin
                    state       <= ST_IDLE;
                    o_dump_done <= 1'b0;
                    o_dump_busy <= 1'b0;
                end
                default: begin
                    state        <= ST_IDLE;
                    o_dump_valid <= 1'b0;
                    o_dump_busy  <= 1'b0;
                    o_dump_done  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_id_register_file_dbg.sv
// Scoreboard bench for id_register_file_dbg: dump beats are queued when a dump
// is launched and checked by a separate negedge monitor; reads are checked
// directly against hand-computed values.
module tb_id_register_file_dbg;

    localparam int NB_DATA  = 32;
    localparam int NB_REG   = 5;
    localparam int SIZE_REG = 32;
    localparam int N_READ   = 2;

    logic                      i_clk;
    logic                      i_rst_n;
    logic [N_READ*NB_REG-1:0]  i_rd_addr;
    logic [N_READ*NB_DATA-1:0] o_rd_data;
    logic                      i_write;
    logic [NB_REG-1:0]         i_address_data;
    logic [NB_DATA-1:0]        i_data_input;
    logic                      i_dump_start;
    logic                      i_dump_ready;
    logic                      o_dump_valid;
    logic [NB_REG-1:0]         o_dump_addr;
    logic [NB_DATA-1:0]        o_dump_data;
    logic                      o_dump_busy;
    logic                      o_dump_done;

    id_register_file_dbg #(
        .NB_DATA  (NB_DATA),
        .NB_REG   (NB_REG),
        .SIZE_REG (SIZE_REG),
        .N_READ   (N_READ)
    ) dut (
        .i_clk          (i_clk),
        .i_rst_n        (i_rst_n),
        .i_rd_addr      (i_rd_addr),
        .o_rd_data      (o_rd_data),
        .i_write        (i_write),
        .i_address_data (i_address_data),
        .i_data_input   (i_data_input),
        .i_dump_start   (i_dump_start),
        .i_dump_ready   (i_dump_ready),
        .o_dump_valid   (o_dump_valid),
        .o_dump_addr    (o_dump_addr),
        .o_dump_data    (o_dump_data),
        .o_dump_busy    (o_dump_busy),
        .o_dump_done    (o_dump_done)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    typedef struct {
        logic [NB_REG-1:0]  a;
        logic [NB_DATA-1:0] d;
    } beat_t;

    beat_t exp_q[$];
    int    checks   = 0;
    int    errors   = 0;
    int    done_cnt = 0;
    int    busy_cnt = 0;
    bit    prev_last = 1'b0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every accepted beat, tracks busy/done.
    always @(negedge i_clk) begin
        beat_t b;
        if (o_dump_busy) busy_cnt++;
        if (o_dump_done) begin
            done_cnt++;
            chk("done_after_last_beat", {31'b0, prev_last}, 32'd1);
        end
        prev_last = 1'b0;
        if (o_dump_valid && i_dump_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL dump_unexpected_beat: got addr %0d data 0x%08h, none expected",
                         o_dump_addr, o_dump_data);
            end else begin
                b = exp_q.pop_front();
                chk($sformatf("dump_addr_%0d", b.a), {27'b0, o_dump_addr}, {27'b0, b.a});
                chk($sformatf("dump_data_%0d", b.a), o_dump_data, b.d);
                prev_last = (o_dump_addr == 5'd31);
            end
        end
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic wr(input logic [NB_REG-1:0] a, input logic [NB_DATA-1:0] d);
        i_write        = 1'b1;
        i_address_data = a;
        i_data_input   = d;
        step();
        i_write        = 1'b0;
    endtask

    task automatic rd_all(input string name, input logic [NB_REG-1:0] a,
                          input logic [NB_DATA-1:0] exp);
        for (int k = 0; k < N_READ; k++) i_rd_addr[k*NB_REG +: NB_REG] = a;
        #1;
        for (int k = 0; k < N_READ; k++)
            chk($sformatf("%s_p%0d", name, k), o_rd_data[k*NB_DATA +: NB_DATA], exp);
    endtask

    task automatic push_dump(input int n, input bit snoop9);
        beat_t b;
        for (int i = 0; i < n; i++) begin
            b.a = i[NB_REG-1:0];
            b.d = (snoop9 && i == 9) ? 32'h0000BEEF : i * 32'h100;
            exp_q.push_back(b);
        end
    endtask

    task automatic wait_done();
        for (int c = 0; c < 200 && done_cnt == 0; c++) step();
        step();
        step();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [NB_DATA-1:0] exp3;
        i_rst_n        = 1'b0;
        i_rd_addr      = '0;
        i_write        = 1'b0;
        i_address_data = '0;
        i_data_input   = '0;
        i_dump_start   = 1'b0;
        i_dump_ready   = 1'b0;
        #1;
        chk("rst_valid", {31'b0, o_dump_valid}, 32'd0);
        chk("rst_busy",  {31'b0, o_dump_busy},  32'd0);
        chk("rst_done",  {31'b0, o_dump_done},  32'd0);
        chk("rst_addr",  {27'b0, o_dump_addr},  32'd0);
        chk("rst_data",  o_dump_data,           32'd0);
        step();
        step();
        i_rst_n = 1'b1;
        step();

        // Asynchronous clear.
        wr(5'd5, 32'hDEADBEEF);
        rd_all("t1_r5_written", 5'd5, 32'hDEADBEEF);
        i_rst_n = 1'b0;
        rd_all("t1_r5_async_clear", 5'd5, 32'h0);
        repeat (3) step();
        i_rst_n = 1'b1;
        step();

        // r0 protection and r31 boundary.
        wr(5'd0, 32'h12345678);
        rd_all("t2_r0", 5'd0, 32'h0);
        wr(5'd31, 32'hCAFEF00D);
        rd_all("t2_r31", 5'd31, 32'hCAFEF00D);
        i_rd_addr = {5'd0, 5'd31};
        #1;
        chk("t2_indep_p0", o_rd_data[31:0],  32'hCAFEF00D);
        chk("t2_indep_p1", o_rd_data[63:32], 32'h0);
        step();

        // Same-cycle read/write collision on r7.
        wr(5'd7, 32'h11);
        i_rd_addr      = {5'd0, 5'd7};
        i_write        = 1'b1;
        i_address_data = 5'd7;
        i_data_input   = 32'h0000AAAA;
`ifdef REGFILE_WRITE_BYPASS_EN
        exp3 = 32'h0000AAAA;
`else
        exp3 = 32'h00000011;
`endif
        #1;
        chk("t3_collision", o_rd_data[31:0], exp3);
        step();
        i_write = 1'b0;
        #1;
        chk("t3_after_write", o_rd_data[31:0], 32'h0000AAAA);

        // Full-speed dump.
        for (int n = 1; n < SIZE_REG; n++) wr(n[NB_REG-1:0], n * 32'h100);
        busy_cnt = 0;
        done_cnt = 0;
        push_dump(SIZE_REG, 1'b0);
        i_dump_ready = 1'b1;
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        wait_done();
        chk("t4_done_count", done_cnt, 32'd1);
        chk("t4_busy_cycles", busy_cnt, 32'd33);
        chk("t4_queue_empty", exp_q.size(), 32'd0);
        chk("t4_busy_low", {31'b0, o_dump_busy}, 32'd0);

        // Stall with snoop on r9, plus ignored restart mid-dump.
        busy_cnt = 0;
        done_cnt = 0;
        push_dump(SIZE_REG, 1'b1);
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        for (int c = 0; c < 100 && !(o_dump_valid && o_dump_addr == 5'd9); c++) step();
        i_dump_ready   = 1'b0;
        i_write        = 1'b1;
        i_address_data = 5'd9;
        i_data_input   = 32'h0000BEEF;
        step();
        i_write = 1'b0;
        chk("t5_stall_addr", {27'b0, o_dump_addr}, 32'd9);
        chk("t5_snoop_data", o_dump_data, 32'h0000BEEF);
        step();
        chk("t5_stall_hold", {27'b0, o_dump_addr}, 32'd9);
        i_dump_ready = 1'b1;
        for (int c = 0; c < 100 && o_dump_addr != 5'd15; c++) step();
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        wait_done();
        chk("t5_done_count", done_cnt, 32'd1);
        chk("t5_busy_cycles", busy_cnt, 32'd35);
        chk("t5_queue_empty", exp_q.size(), 32'd0);

        // Reset mid-dump after beat 4.
        done_cnt = 0;
        push_dump(5, 1'b0);
        i_dump_start = 1'b1;
        step();
        i_dump_start = 1'b0;
        for (int c = 0; c < 100 && o_dump_addr != 5'd5; c++) step();
        i_rst_n = 1'b0;
        #1;
        chk("t6_valid_cleared", {31'b0, o_dump_valid}, 32'd0);
        chk("t6_busy_cleared",  {31'b0, o_dump_busy},  32'd0);
        repeat (3) step();
        i_rst_n = 1'b1;
        repeat (3) step();
        chk("t6_no_done", done_cnt, 32'd0);
        chk("t6_queue_empty", exp_q.size(), 32'd0);
        rd_all("t6_regs_cleared", 5'd31, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
